// File: rtl/bram_axis_reader_pkg.sv
// bram_axis_reader_pkg: shared widths and FSM encoding for the BRAM<->AXIS adapters
package bram_axis_reader_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_BRAM_WIDTH = 1152;
   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_WORDS_PER_LINE = DEF_BRAM_WIDTH / DEF_DATA_WIDTH;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, STREAM, FIN} state_t;
endpackage

// File: rtl/bram_axis_reader_if.sv
// bram_axis_reader_if: AXI-Stream master/slave bundle
interface bram_axis_reader_if #(parameter int DW = bram_axis_reader_pkg::DEF_DATA_WIDTH);
   logic          tvalid;
   logic          tready;
   logic          tlast;
   logic [DW-1:0] tdata;
   logic [DW/8-1:0] tstrb;
   modport master(output tvalid, tdata, tstrb, tlast, input tready);
   modport slave(input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/bram_line_serializer.sv
// bram_line_serializer: holds one BRAM line and emits it LSW-first as AXIS beats
module bram_line_serializer import bram_axis_reader_pkg::*; #(
   parameter int DW = DEF_DATA_WIDTH,
   parameter int BW = DEF_BRAM_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [BW-1:0] line,
   input  logic          is_last_line,
   input  logic          tready,
   output logic          tvalid,
   output logic [DW-1:0] tdata,
   output logic [DW/8-1:0] tstrb,
   output logic          tlast,
   output logic          line_done
);
   localparam int WPL = BW / DW;
   localparam int CW = $clog2(WPL);
   logic [BW-1:0] line_r;
   logic [CW-1:0] word_cnt;
   logic          last_word;
   logic [CW-1:0] nxt;
   assign last_word = word_cnt == CW'(WPL - 1);
   assign nxt = last_word ? '0 : word_cnt + CW'(1);
   assign line_done = tvalid && tready && last_word;
   // tdata/tlast are pre-computed for the next word so they stay registered and stable under stall
   always_ff @(posedge clk) begin
      if (rst) begin
         line_r <= '0;
         word_cnt <= '0;
         tvalid <= 1'b0;
         tdata <= '0;
         tstrb <= '0;
         tlast <= 1'b0;
      end else if (load) begin
         line_r <= line;
         word_cnt <= '0;
         tvalid <= 1'b1;
         tdata <= line[DW-1:0];
         tstrb <= '1;
         tlast <= is_last_line && (WPL == 1);
      end else if (tvalid && tready) begin
         word_cnt <= nxt;
         tvalid <= !last_word;
         tdata <= line_r[DW*int'(nxt) +: DW];
         tlast <= is_last_line && (nxt == CW'(WPL - 1));
      end
   end
endmodule

// File: rtl/bram_axis_reader.sv
// bram_axis_reader: streams BRAM lines start..bound (inclusive, wrapping) out as AXIS words
module bram_axis_reader import bram_axis_reader_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BRAM_WIDTH = DEF_BRAM_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  m00_axis_aclk,
   input  logic                  m00_axis_areset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] bram_start_addr,
   input  logic [ADDR_WIDTH-1:0] bram_bound_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  BRAM_EN,
   output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
   input  logic [BRAM_WIDTH-1:0] BRAM_OUT,
   bram_axis_reader_if.master    m00_axis
);
   state_t state;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [ADDR_WIDTH-1:0] bound_addr;
   logic line_done;
   bram_line_serializer #(.DW(DATA_WIDTH), .BW(BRAM_WIDTH)) u_ser (
      .clk(m00_axis_aclk),
      .rst(m00_axis_areset),
      .load(state == WAIT),
      .line(BRAM_OUT),
      .is_last_line(cur_addr == bound_addr),
      .tready(m00_axis.tready),
      .tvalid(m00_axis.tvalid),
      .tdata(m00_axis.tdata),
      .tstrb(m00_axis.tstrb),
      .tlast(m00_axis.tlast),
      .line_done(line_done)
   );
   // BRAM_EN is raised on the transition into REQ so it is high exactly during REQ
   always_ff @(posedge m00_axis_aclk) begin
      if (m00_axis_areset) begin
         state <= IDLE;
         cur_addr <= '0;
         bound_addr <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         BRAM_EN <= 1'b0;
         BRAM_ADDR <= '0;
      end else begin
         BRAM_EN <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               cur_addr <= bram_start_addr;
               bound_addr <= bram_bound_addr;
               busy <= 1'b1;
               BRAM_EN <= 1'b1;
               BRAM_ADDR <= bram_start_addr;
               state <= REQ;
            end
            REQ: state <= WAIT;
            WAIT: state <= STREAM;
            STREAM: if (line_done) begin
               if (cur_addr == bound_addr) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  state <= FIN;
               end else begin
                  cur_addr <= cur_addr + ADDR_WIDTH'(1);
                  BRAM_ADDR <= cur_addr + ADDR_WIDTH'(1);
                  BRAM_EN <= 1'b1;
                  state <= REQ;
               end
            end
            FIN: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bram_axis_reader.sv
// tb_bram_axis_reader: directed scenarios for the BRAM->AXIS reader
module tb_bram_axis_reader;
   localparam int DW = 32;
   localparam int BW = 1152;
   localparam int AW = 12;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [AW-1:0] sa = '0;
   logic [AW-1:0] ba = '0;
   logic busy, done, bram_en;
   logic [AW-1:0] bram_addr;
   logic [BW-1:0] bram_out = '0;
   int cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;
   logic [31:0] bd[$];
   bit bl[$];
   int bc[$];
   int ea[$];
   int en_cyc, done_cyc, start_cyc, stab_err, strb_err;

   bram_axis_reader_if #(.DW(DW)) axis();

   bram_axis_reader dut (
      .m00_axis_aclk(clk),
      .m00_axis_areset(rst),
      .start(start),
      .bram_start_addr(sa),
      .bram_bound_addr(ba),
      .busy(busy),
      .done(done),
      .BRAM_EN(bram_en),
      .BRAM_ADDR(bram_addr),
      .BRAM_OUT(bram_out),
      .m00_axis(axis)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] exp_word(input int a, input int k);
      return 32'(a * 36 + k + 1);
   endfunction

   function automatic logic [BW-1:0] line_of(input logic [AW-1:0] a);
      logic [BW-1:0] l;
      for (int k = 0; k < 36; k++) l[32*k +: 32] = exp_word(int'(a), k);
      return l;
   endfunction

   // registered BRAM: data appears the cycle after the enable
   always @(posedge clk) if (bram_en) bram_out <= line_of(bram_addr);

   task automatic collect(input int s, input int b, input int bp, input int inj, input int max_cyc);
      bit prev_stall = 0;
      logic [31:0] pd = '0;
      bit pl = 0;
      bit injd = 0;
      bd.delete(); bl.delete(); bc.delete(); ea.delete();
      en_cyc = -1; done_cyc = -1; stab_err = 0; strb_err = 0;
      @(negedge clk);
      sa = AW'(s); ba = AW'(b); start = 1'b1; start_cyc = cyc;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (inj >= 0 && !injd && bd.size() == inj) begin
            start = 1'b1; sa = AW'(s + 100); ba = AW'(b + 50); injd = 1;
         end
         axis.tready = (bp == 0) || ($urandom_range(99) >= bp);
         if (bram_en) begin
            ea.push_back(int'(bram_addr));
            if (en_cyc < 0) en_cyc = cyc;
         end
         if (prev_stall && (!axis.tvalid || axis.tdata !== pd || axis.tlast !== pl)) stab_err++;
         if (axis.tvalid) begin
            if (axis.tstrb !== 4'hF) strb_err++;
            if (axis.tready) begin
               bd.push_back(axis.tdata); bl.push_back(axis.tlast); bc.push_back(cyc);
            end
         end
         prev_stall = axis.tvalid && !axis.tready;
         pd = axis.tdata; pl = axis.tlast;
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      start = 1'b0;
      axis.tready = 1'b1;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_cmp++; if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", axis.tvalid); end
      n_cmp++; if (axis.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b want 0", axis.tlast); end
      n_cmp++; if (axis.tdata !== 32'h0) begin n_fail++; $display("FAIL reset_tdata got %h want 0", axis.tdata); end
      n_cmp++; if (axis.tstrb !== 4'h0) begin n_fail++; $display("FAIL reset_tstrb got %h want 0", axis.tstrb); end
      n_cmp++; if (bram_en !== 1'b0 || bram_addr !== '0) begin n_fail++; $display("FAIL reset_bram en=%b addr=%0d want 0/0", bram_en, bram_addr); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done busy=%b done=%b want 0/0", busy, done); end
      rst = 1'b0;
   endtask

   task automatic test_single_line;
      collect(0, 0, 0, -1, 200);
      n_cmp++; if (bd.size() != 36) begin n_fail++; $display("FAIL t1_beats got %0d want 36", bd.size()); end
      for (int k = 0; k < bd.size(); k++) begin
         n_cmp++;
         if (bd[k] !== 32'(k + 1) || bl[k] !== (k == 35)) begin
            n_fail++; $display("FAIL t1_beat%0d got %0d/last=%b want %0d/last=%b", k, bd[k], bl[k], k + 1, k == 35);
         end
      end
      n_cmp++; if (en_cyc - start_cyc != 1) begin n_fail++; $display("FAIL t1_en_latency got %0d want 1", en_cyc - start_cyc); end
      n_cmp++; if ((bc.size() > 0 ? bc[0] - start_cyc : -1) != 3) begin n_fail++; $display("FAIL t1_tvalid_latency got %0d want 3", bc.size() > 0 ? bc[0] - start_cyc : -1); end
      n_cmp++; if (done_cyc != (bc.size() > 0 ? bc[bc.size()-1] + 1 : -2)) begin n_fail++; $display("FAIL t1_done got cyc %0d want last beat + 1", done_cyc); end
      n_cmp++; if (ea.size() != 1 || (ea.size() > 0 && ea[0] != 0)) begin n_fail++; $display("FAIL t1_bram_reads got %0d reads want 1 of line 0", ea.size()); end
      n_cmp++; if (strb_err != 0) begin n_fail++; $display("FAIL t1_tstrb got %0d bad beats want 0", strb_err); end
   endtask

   task automatic test_multi_line;
      collect(0, 7, 0, -1, 1000);
      n_cmp++; if (bd.size() != 288) begin n_fail++; $display("FAIL t2_beats got %0d want 288", bd.size()); end
      for (int i = 0; i < bd.size(); i++) begin
         n_cmp++;
         if (bd[i] !== 32'(i + 1) || bl[i] !== (i == 287)) begin
            n_fail++; $display("FAIL t2_beat%0d got %0d/last=%b want %0d/last=%b", i, bd[i], bl[i], i + 1, i == 287);
         end
      end
      n_cmp++; if (ea.size() != 8) begin n_fail++; $display("FAIL t2_reads got %0d want 8", ea.size()); end
      for (int l = 0; l < ea.size(); l++) begin
         n_cmp++; if (ea[l] != l) begin n_fail++; $display("FAIL t2_addr%0d got %0d want %0d", l, ea[l], l); end
      end
      for (int l = 1; l < 8 && 36 * l < bc.size(); l++) begin
         n_cmp++; if (bc[36*l] - bc[36*l-1] != 3) begin n_fail++; $display("FAIL t2_gap%0d got %0d want 3", l, bc[36*l] - bc[36*l-1]); end
      end
      n_cmp++; if (done_cyc - en_cyc != 304) begin n_fail++; $display("FAIL t2_total got %0d want 304", done_cyc - en_cyc); end
   endtask

   task automatic test_backpressure;
      collect(0, 7, 40, -1, 3000);
      n_cmp++; if (bd.size() != 288) begin n_fail++; $display("FAIL t3_beats got %0d want 288", bd.size()); end
      for (int i = 0; i < bd.size(); i++) begin
         n_cmp++;
         if (bd[i] !== 32'(i + 1) || bl[i] !== (i == 287)) begin
            n_fail++; $display("FAIL t3_beat%0d got %0d/last=%b want %0d/last=%b", i, bd[i], bl[i], i + 1, i == 287);
         end
      end
      n_cmp++; if (stab_err != 0) begin n_fail++; $display("FAIL t3_stall_stable got %0d violations want 0", stab_err); end
      n_cmp++; if (strb_err != 0) begin n_fail++; $display("FAIL t3_tstrb got %0d bad beats want 0", strb_err); end
   endtask

   task automatic test_wrap;
      int wl[4] = '{4094, 4095, 0, 1};
      collect(4094, 1, 0, -1, 1000);
      n_cmp++; if (bd.size() != 144) begin n_fail++; $display("FAIL t4_beats got %0d want 144", bd.size()); end
      n_cmp++; if (ea.size() != 4) begin n_fail++; $display("FAIL t4_reads got %0d want 4", ea.size()); end
      for (int l = 0; l < 4 && l < ea.size(); l++) begin
         n_cmp++; if (ea[l] != wl[l]) begin n_fail++; $display("FAIL t4_addr%0d got %0d want %0d", l, ea[l], wl[l]); end
      end
      for (int i = 0; i < bd.size() && i < 144; i++) begin
         n_cmp++;
         if (bd[i] !== exp_word(wl[i/36], i % 36) || bl[i] !== (i == 143)) begin
            n_fail++; $display("FAIL t4_beat%0d got %0d/last=%b want %0d/last=%b", i, bd[i], bl[i], exp_word(wl[i/36], i % 36), i == 143);
         end
      end
   endtask

   task automatic test_reset_mid_stream;
      int cnt = 0;
      bit hit = 0;
      @(negedge clk);
      sa = AW'(0); ba = AW'(7); start = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (axis.tvalid) begin
            if (cnt == 82) begin
               axis.tready = 1'b0; rst = 1'b1; hit = 1;
               break;
            end
            cnt++;
         end
      end
      n_cmp++; if (!hit) begin n_fail++; $display("FAIL t5_reach got %0d beats want 82", cnt); end
      n_cmp++; if (axis.tdata !== exp_word(2, 10)) begin n_fail++; $display("FAIL t5_presented got %0d want %0d", axis.tdata, exp_word(2, 10)); end
      @(negedge clk);
      n_cmp++; if (axis.tvalid !== 1'b0 || bram_en !== 1'b0 || busy !== 1'b0 || axis.tlast !== 1'b0) begin
         n_fail++; $display("FAIL t5_abort tvalid=%b en=%b busy=%b tlast=%b want 0000", axis.tvalid, bram_en, busy, axis.tlast);
      end
      rst = 1'b0;
      axis.tready = 1'b1;
      collect(5, 5, 0, -1, 200);
      n_cmp++; if (bd.size() != 36) begin n_fail++; $display("FAIL t5_beats got %0d want 36", bd.size()); end
      for (int k = 0; k < bd.size(); k++) begin
         n_cmp++;
         if (bd[k] !== exp_word(5, k) || bl[k] !== (k == 35)) begin
            n_fail++; $display("FAIL t5_beat%0d got %0d/last=%b want %0d/last=%b", k, bd[k], bl[k], exp_word(5, k), k == 35);
         end
      end
   endtask

   task automatic test_start_while_busy;
      collect(2, 3, 0, 20, 400);
      n_cmp++; if (bd.size() != 72) begin n_fail++; $display("FAIL t6_beats got %0d want 72", bd.size()); end
      n_cmp++; if (ea.size() != 2 || (ea.size() == 2 && (ea[0] != 2 || ea[1] != 3))) begin
         n_fail++; $display("FAIL t6_reads got %0d reads want lines 2,3", ea.size());
      end
      for (int i = 0; i < bd.size(); i++) begin
         n_cmp++;
         if (bd[i] !== exp_word(2 + i / 36, i % 36) || bl[i] !== (i == 71)) begin
            n_fail++; $display("FAIL t6_beat%0d got %0d/last=%b want %0d/last=%b", i, bd[i], bl[i], exp_word(2 + i / 36, i % 36), i == 71);
         end
      end
      repeat (3) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t6_idle_after busy=%b want 0", busy); end
   endtask

   initial begin
      axis.tready = 1'b1;
      test_reset;
      test_single_line;
      test_multi_line;
      test_backpressure;
      test_wrap;
      test_reset_mid_stream;
      test_start_while_busy;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
